// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide unit: one shift-add or restoring-subtract step per clock.
// Optional signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iWrHi,
  input  logic             iWrLo,
  input  logic [WIDTH-1:0] iWrData,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] upper_q;
  logic [WIDTH-1:0] lower_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             divzero_q;

  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   rem_sh_d;
  logic [WIDTH:0]   rem_sub_d;
  logic             ge_d;
  logic [WIDTH-1:0] upper_d;
  logic [WIDTH-1:0] lower_d;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] a_lat_d;
  logic [WIDTH-1:0] b_lat_d;
  logic             last_d;

`ifdef MULDIV_SIGNED_EN
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] a_orig_q;
  logic             a_neg_d;
  logic             b_neg_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return -v;
  endfunction

  // Signed operands run through the unsigned datapath as magnitudes.
  always_comb begin
    a_neg_d = iOp[1] & iA[WIDTH-1];
    b_neg_d = iOp[1] & iB[WIDTH-1];
    a_lat_d = a_neg_d ? neg_w(iA) : iA;
    b_lat_d = b_neg_d ? neg_w(iB) : iB;
  end
`else
  logic unused_op;
  assign unused_op = iOp[1];

  always_comb begin
    a_lat_d = iA;
    b_lat_d = iB;
  end
`endif

  // One iteration of either algorithm; lower_q holds multiplier or dividend/quotient.
  always_comb begin
    sum_d     = {1'b0, upper_q} + (lower_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_sh_d  = {upper_q, lower_q[WIDTH-1]};
    ge_d      = (rem_sh_d >= {1'b0, b_q});
    rem_sub_d = rem_sh_d - {1'b0, b_q};
    if (is_div_q) begin
      upper_d = ge_d ? rem_sub_d[WIDTH-1:0] : rem_sh_d[WIDTH-1:0];
      lower_d = {lower_q[WIDTH-2:0], ge_d};
    end else begin
      upper_d = sum_d[WIDTH:1];
      lower_d = {sum_d[0], lower_q[WIDTH-1:1]};
    end
    hi_d = upper_d;
    lo_d = lower_d;
`ifdef MULDIV_SIGNED_EN
    if (is_div_q) begin
      if (b_q == '0) begin
        hi_d = a_orig_q;
        lo_d = '1;
      end else begin
        hi_d = neg_rem_q ? neg_w(upper_d) : upper_d;
        lo_d = neg_res_q ? neg_w(lower_d) : lower_d;
      end
    end else if (neg_res_q) begin
      {hi_d, lo_d} = neg_2w({upper_d, lower_d});
    end
`endif
    last_d = (cnt_q == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge Clk or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      b_q       <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_orig_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          divzero_q <= 1'b0;
          if (iStart) begin
            cnt_q    <= '0;
            is_div_q <= iOp[0];
            upper_q  <= '0;
            lower_q  <= a_lat_d;
            b_q      <= b_lat_d;
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= a_neg_d ^ b_neg_d;
            neg_rem_q <= a_neg_d;
            a_orig_q  <= iA;
`endif
          end else begin
            if (iWrHi) hi_q <= iWrData;
            if (iWrLo) lo_q <= iWrData;
          end
        end
        RUN: begin
          upper_q <= upper_d;
          lower_q <= lower_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_d) begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= 1'b1;
            divzero_q <= is_div_q && (b_q == '0);
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q    <= 1'b0;
          divzero_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oDivZero = divzero_q;
  assign oHi      = hi_q;
  assign oLo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; signed vectors run when MULDIV_SIGNED_EN is defined.
module tb_muldiv_sequencer;

  logic        Clk;
  logic        iReset;
  logic        iStart;
  logic [1:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iWrHi;
  logic        iWrLo;
  logic [31:0] iWrData;
  logic        oBusy;
  logic        oDone;
  logic        oDivZero;
  logic [31:0] oHi;
  logic [31:0] oLo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk      (Clk),
    .iReset   (iReset),
    .iStart   (iStart),
    .iOp      (iOp),
    .iA       (iA),
    .iB       (iB),
    .iWrHi    (iWrHi),
    .iWrLo    (iWrLo),
    .iWrData  (iWrData),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oDivZero (oDivZero),
    .oHi      (oHi),
    .oLo      (oLo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called just after the start edge; returns cycles to oDone and oBusy cycles seen.
  task automatic wait_done(output int lat, output int busy_n, output logic dz);
    lat = 0;
    busy_n = 0;
    while (!oDone && lat < 100) begin
      if (oBusy) busy_n++;
      @(negedge Clk);
      lat++;
    end
    dz = oDivZero;
    if (oBusy) busy_n++;
    @(negedge Clk);
    if (oBusy) busy_n++;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output logic dz);
    @(negedge Clk);
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    @(negedge Clk);
    iStart = 1'b0;
    wait_done(lat, busy_n, dz);
  endtask

  initial begin
    int   lat;
    int   busy_n;
    logic dz;
    int   done_seen;

    iReset = 1'b1; iStart = 1'b0; iOp = 2'b00; iA = '0; iB = '0;
    iWrHi = 1'b0; iWrLo = 1'b0; iWrData = '0;
    #1;
    chk("reset_busy", {63'd0, oBusy}, 64'd0);
    chk("reset_done", {63'd0, oDone}, 64'd0);
    chk("reset_hilo", {oHi, oLo}, 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    iReset = 1'b0;

    // T1: MULTU max*max, latency and busy length
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_n, dz);
    chk("t1_latency", 64'(lat), 64'd32);
    chk("t1_busy_cycles", 64'(busy_n), 64'd33);
    chk("t1_hilo", {oHi, oLo}, 64'hFFFFFFFE_00000001);

    // T2: DIVU normal and divide by zero
    run_op(2'b01, 32'd100, 32'd7, lat, busy_n, dz);
    chk("t2_div_hilo", {oHi, oLo}, {32'd2, 32'd14});
    chk("t2_div_dz", {63'd0, dz}, 64'd0);
    run_op(2'b01, 32'h1234, 32'd0, lat, busy_n, dz);
    chk("t2_dz_latency", 64'(lat), 64'd32);
    chk("t2_dz_hilo", {oHi, oLo}, 64'h00001234_FFFFFFFF);
    chk("t2_dz_flag", {63'd0, dz}, 64'd1);

    // T3: start and MTHI/MTLO ignored while busy, operands latched
    @(negedge Clk);
    iOp = 2'b00; iA = 32'd6; iB = 32'd7; iStart = 1'b1;
    @(negedge Clk);
    iStart = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge Clk);
      if (i == 5 || i == 20) begin
        iStart = 1'b1; iWrHi = 1'b1; iWrLo = 1'b1; iWrData = 32'hBEEF; iA = 32'd9; iB = 32'd9;
        iOp = 2'b01;
      end else begin
        iStart = 1'b0; iWrHi = 1'b0; iWrLo = 1'b0;
      end
      if (i == 10) chk("t3_hi_held", {oHi, oLo}, 64'h00001234_FFFFFFFF);
    end
    iStart = 1'b0; iWrHi = 1'b0; iWrLo = 1'b0;
    lat = 0;
    while (!oDone && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    chk("t3_done_seen", {63'd0, oDone}, 64'd1);
    chk("t3_hilo", {oHi, oLo}, {32'd0, 32'd42});
    @(negedge Clk);
    iWrHi = 1'b1; iWrData = 32'hDEAD;
    @(negedge Clk);
    iWrHi = 1'b0;
    chk("t3_mthi", {oHi, oLo}, {32'hDEAD, 32'd42});
    iWrHi = 1'b1; iWrLo = 1'b1; iWrData = 32'h0000_C0DE;
    @(negedge Clk);
    iWrHi = 1'b0; iWrLo = 1'b0;
    chk("t3_both_write", {oHi, oLo}, {32'hC0DE, 32'hC0DE});
    iOp = 2'b00; iA = 32'd2; iB = 32'd3; iStart = 1'b1; iWrLo = 1'b1; iWrData = 32'h5555;
    @(negedge Clk);
    iStart = 1'b0; iWrLo = 1'b0;
    chk("t3_start_wins_lo", {32'd0, oLo}, {32'd0, 32'hC0DE});
    chk("t3_start_busy", {63'd0, oBusy}, 64'd1);
    wait_done(lat, busy_n, dz);
    chk("t3_second_hilo", {oHi, oLo}, {32'd0, 32'd6});

    // T4: asynchronous reset mid-operation
    iWrHi = 1'b1; iWrData = 32'hAAAA;
    @(negedge Clk);
    iWrHi = 1'b0;
    iOp = 2'b01; iA = 32'd100; iB = 32'd7; iStart = 1'b1;
    @(negedge Clk);
    iStart = 1'b0;
    repeat (10) @(negedge Clk);
    #2 iReset = 1'b1;
    #1;
    chk("t4_rst_busy", {63'd0, oBusy}, 64'd0);
    chk("t4_rst_hilo", {oHi, oLo}, 64'd0);
    @(negedge Clk);
    iReset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (oDone || oBusy) done_seen++;
    end
    chk("t4_no_done", 64'(done_seen), 64'd0);
    run_op(2'b01, 32'd100, 32'd7, lat, busy_n, dz);
    chk("t4_after_latency", 64'(lat), 64'd32);
    chk("t4_after_hilo", {oHi, oLo}, {32'd2, 32'd14});

`ifdef MULDIV_SIGNED_EN
    // T5: signed operations
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, lat, busy_n, dz);
    chk("t5_mult", {oHi, oLo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, busy_n, dz);
    chk("t5_div_negdividend", {oHi, oLo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'b11, 32'd7, 32'hFFFFFFFE, lat, busy_n, dz);
    chk("t5_div_negdivisor", {oHi, oLo}, 64'h00000001_FFFFFFFD);
    run_op(2'b11, 32'hFFFFFFF9, 32'd0, lat, busy_n, dz);
    chk("t5_div_zero", {oHi, oLo}, 64'hFFFFFFF9_FFFFFFFF);
    chk("t5_div_zero_flag", {63'd0, dz}, 64'd1);
`else
    // T6: signed opcodes behave as unsigned
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, lat, busy_n, dz);
    chk("t6_mult_unsigned", {oHi, oLo}, 64'h00000004_FFFFFFF1);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, busy_n, dz);
    chk("t6_div_unsigned", {oHi, oLo}, 64'h00000001_7FFFFFFC);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
